// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg
// Shared types and constants for the interrupt scheduler.
//   state_t      : scheduler FSM states (IDLE, SERVE, GAP)
//   MISSED_CNT_W : width of each per-source missed-edge counter
//   id_width()   : source-ID width, clog2 with a floor of one bit
package irq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int MISSED_CNT_W = 8;

  function automatic int id_width(input int n);
    if (n <= 2) return 1;
    else return $clog2(n);
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync
// One interrupt source: synchronizer chain, delay flop and a registered
// edge pulse whose polarity is chosen by cfg_fall.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   src        : raw asynchronous interrupt line
//   cfg_fall   : 0 = rising edge, 1 = falling edge
//   pulse      : one-cycle registered edge pulse
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic cfg_fall,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Everything resets to 0, so a line held high across reset is seen as a
  // rising edge once reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      dly_q  <= sync_out;
      pulse  <= cfg_fall ? (~sync_out & dly_q) : (sync_out & ~dly_q);
    end
  end

endmodule

// File: rtl/irq_scheduler.sv
// irq_scheduler
// Collects NUM_SRC asynchronous interrupt lines into a single level
// interrupt with a source ID and a one-cycle ack handshake. Sources are
// served round-robin; after each ack irq_o stays low for HOLDOFF cycles.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   src_i         : raw asynchronous interrupt lines
//   cfg_fall_i    : per-source edge select (0 rising, 1 falling)
//   en_i          : per-source arbitration enable
//   clr_i         : one-cycle software clear of pending bits
//   ack_i         : one-cycle acknowledge of the presented ID
//   irq_o         : level interrupt to the PS
//   irq_id_o      : ID of the presented source, valid while irq_o=1
//   pending_o     : sticky pending bits
//   missed_cnt_o  : per-source 8-bit saturating missed-edge counters,
//                   present only when IRQ_MISSED_CNT_EN is defined
module irq_scheduler
  import irq_sched_pkg::*;
#(
  parameter  int NUM_SRC     = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int HOLDOFF     = 4,
  localparam int ID_W        = id_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] cfg_fall_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic [NUM_SRC-1:0] clr_i,
  input  logic               ack_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [NUM_SRC-1:0] pending_o
`ifdef IRQ_MISSED_CNT_EN
  ,
  output logic [MISSED_CNT_W*NUM_SRC-1:0] missed_cnt_o
`endif
);

  localparam logic [7:0] HOLD_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  logic [NUM_SRC-1:0] pulse;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] ack_mask;
  state_t             state_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    last_id_q;
  logic [ID_W-1:0]    grant;
  logic               grant_valid;
  logic [7:0]         hold_q;
  logic               ack_fire;
  int                 rr_idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (src_i[i]),
      .cfg_fall (cfg_fall_i[i]),
      .pulse    (pulse[i])
    );
  end

  assign req      = pending_q & en_i;
  assign ack_fire = (state_q == SERVE) && ack_i;
  assign ack_mask = ack_fire ? (NUM_SRC'(1) << id_q) : '0;

  // A new edge wins over clr_i or ack in the same cycle, so it is never lost
  // to a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= (pending_q & ~(clr_i | ack_mask)) | pulse;
  end

  // Round-robin search starting just after last_id. Walking distances from
  // farthest to nearest lets the nearest requesting source overwrite the
  // others without a separate found flag.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_idx      = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      rr_idx = int'(last_id_q) + k;
      if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
      if (req[rr_idx]) begin
        grant       = ID_W'(rr_idx);
        grant_valid = 1'b1;
      end
    end
  end

  // Scheduler FSM. Only ack_i leaves SERVE; enable or clear changes on the
  // served source do not withdraw an interrupt already presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      last_id_q <= ID_W'(NUM_SRC - 1);
      hold_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            id_q      <= grant;
            last_id_q <= grant;
            state_q   <= SERVE;
          end
        end
        SERVE: begin
          if (ack_i) begin
            if (HOLDOFF == 0) begin
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
              hold_q  <= HOLD_LOAD;
            end
          end
        end
        GAP: begin
          if (hold_q == 8'd0) state_q <= IDLE;
          else                hold_q  <= hold_q - 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_o     = (state_q == SERVE);
  assign irq_id_o  = id_q;
  assign pending_o = pending_q;

`ifdef IRQ_MISSED_CNT_EN
  logic [NUM_SRC-1:0][MISSED_CNT_W-1:0] missed_q;

  // An edge that lands while the source is already pending is counted as
  // missed; the count saturates and is reset by the same clr_i bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missed_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (clr_i[i]) begin
          missed_q[i] <= '0;
        end else if (pulse[i] && pending_q[i] && (missed_q[i] != '1)) begin
          missed_q[i] <= missed_q[i] + 1'b1;
        end
      end
    end
  end

  assign missed_cnt_o = missed_q;
`endif

endmodule

// File: tb/tb_irq_scheduler.sv
// tb_irq_scheduler
// Directed bench for irq_scheduler (NUM_SRC=8, SYNC_STAGES=2, HOLDOFF=4).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Counter checks are compiled in when IRQ_MISSED_CNT_EN is defined.
module tb_irq_scheduler;

  localparam int NUM_SRC     = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HOLDOFF     = 4;
  localparam int WAIT_MAX    = 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] src_i;
  logic [NUM_SRC-1:0] cfg_fall_i;
  logic [NUM_SRC-1:0] en_i;
  logic [NUM_SRC-1:0] clr_i;
  logic               ack_i;
  logic               irq_o;
  logic [2:0]         irq_id_o;
  logic [NUM_SRC-1:0] pending_o;
`ifdef IRQ_MISSED_CNT_EN
  logic [8*NUM_SRC-1:0] missed_cnt_o;
`endif

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  irq_scheduler #(
    .NUM_SRC     (NUM_SRC),
    .SYNC_STAGES (SYNC_STAGES),
    .HOLDOFF     (HOLDOFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_i        (src_i),
    .cfg_fall_i   (cfg_fall_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .ack_i        (ack_i),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o),
    .pending_o    (pending_o)
`ifdef IRQ_MISSED_CNT_EN
    ,
    .missed_cnt_o (missed_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] src,
                               input logic [NUM_SRC-1:0] en,
                               input logic [NUM_SRC-1:0] fall);
    src_i      = src;
    en_i       = en;
    cfg_fall_i = fall;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    src_i = '0;
    clr_i = '0;
    ack_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic waitIrq(input string tag);
    int n = 0;
    while (!irq_o && n < WAIT_MAX) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(irq_o), 32'd1);
  endtask

  task automatic ackPulse();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic serveExpect(input string tag, input int exp_id);
    waitIrq({tag, "_irq"});
    checkOutput({tag, "_id"}, 32'(irq_id_o), 32'(exp_id));
    ackPulse();
    checkOutput({tag, "_drop"}, 32'(irq_o), 32'd0);
  endtask

  initial begin
    applyStimulus('0, '1, '0);

    // Reset values, then a single rising edge on source 3.
    resetDut();
    checkOutput("rst_irq", 32'(irq_o), 32'd0);
    checkOutput("rst_id", 32'(irq_id_o), 32'd0);
    checkOutput("rst_pending", 32'(pending_o), 32'd0);
`ifdef IRQ_MISSED_CNT_EN
    checkOutput("rst_missed", missed_cnt_o[31:0], 32'd0);
`endif
    applyStimulus(8'h08, 8'hFF, 8'h00);
    repeat (SYNC_STAGES + 1) tick();
    checkOutput("t1_pend_early", 32'(pending_o[3]), 32'd0);
    tick();
    checkOutput("t1_pend_set", 32'(pending_o[3]), 32'd1);
    checkOutput("t1_irq_not_yet", 32'(irq_o), 32'd0);
    tick();
    checkOutput("t1_irq", 32'(irq_o), 32'd1);
    checkOutput("t1_id", 32'(irq_id_o), 32'd3);
    ackPulse();
    checkOutput("t1_pend_clr", 32'(pending_o), 32'd0);
    for (int i = 0; i < HOLDOFF; i++) begin
      checkOutput("t1_gap_low", 32'(irq_o), 32'd0);
      tick();
    end

    // Round-robin: 0,2,5 together from reset, then 0 and 5 after last_id=5.
    resetDut();
    applyStimulus(8'h25, 8'hFF, 8'h00);
    serveExpect("t2_a", 0);
    serveExpect("t2_b", 2);
    serveExpect("t2_c", 5);
    applyStimulus(8'h00, 8'hFF, 8'h00);
    repeat (4) tick();
    applyStimulus(8'h21, 8'hFF, 8'h00);
    serveExpect("t2_d", 0);
    serveExpect("t2_e", 5);

    // Falling-edge source 1 with arbitration disabled at first.
    applyStimulus(8'h00, 8'hFD, 8'h02);
    resetDut();
    src_i[1] = 1'b1;
    repeat (10) tick();
    checkOutput("t3_no_rise", 32'(pending_o[1]), 32'd0);
    src_i[1] = 1'b0;
    repeat (SYNC_STAGES + 1) tick();
    checkOutput("t3_pend_early", 32'(pending_o[1]), 32'd0);
    tick();
    checkOutput("t3_pend_fall", 32'(pending_o[1]), 32'd1);
    repeat (3) tick();
    checkOutput("t3_masked", 32'(irq_o), 32'd0);
    en_i = 8'hFF;
    tick();
    checkOutput("t3_irq", 32'(irq_o), 32'd1);
    checkOutput("t3_id", 32'(irq_id_o), 32'd1);
    ackPulse();

    // Edge on the served source landing in the ack cycle keeps it pending.
    applyStimulus(8'h00, 8'hFF, 8'h00);
    resetDut();
    src_i[4] = 1'b1;
    waitIrq("t4_irq");
    checkOutput("t4_id", 32'(irq_id_o), 32'd4);
    src_i[4] = 1'b0;
    repeat (5) tick();
    src_i[4] = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    ackPulse();
    checkOutput("t4_drop", 32'(irq_o), 32'd0);
    checkOutput("t4_pend_kept", 32'(pending_o[4]), 32'd1);
    for (int i = 1; i < HOLDOFF; i++) begin
      tick();
      checkOutput("t4_gap_low", 32'(irq_o), 32'd0);
    end
    waitIrq("t4_reirq");
    checkOutput("t4_reid", 32'(irq_id_o), 32'd4);
    ackPulse();

    // Lost edges on disabled source 6, then a software clear.
    applyStimulus(8'h00, 8'hBF, 8'h00);
    resetDut();
    src_i[6] = 1'b1;
    repeat (SYNC_STAGES + 3) tick();
    checkOutput("t5_pend", 32'(pending_o[6]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      src_i[6] = 1'b0;
      repeat (2) tick();
      src_i[6] = 1'b1;
      repeat (2) tick();
    end
    repeat (SYNC_STAGES + 3) tick();
`ifdef IRQ_MISSED_CNT_EN
    checkOutput("t5_missed3", 32'(missed_cnt_o[55:48]), 32'd3);
    for (int i = 0; i < 300; i++) begin
      src_i[6] = 1'b0;
      repeat (2) tick();
      src_i[6] = 1'b1;
      repeat (2) tick();
    end
    repeat (SYNC_STAGES + 3) tick();
    checkOutput("t5_missed_sat", 32'(missed_cnt_o[55:48]), 32'd255);
`endif
    checkOutput("t5_pend_kept", 32'(pending_o[6]), 32'd1);
    checkOutput("t5_irq_masked", 32'(irq_o), 32'd0);
    clr_i = 8'h40;
    tick();
    clr_i = 8'h00;
    checkOutput("t5_pend_clr", 32'(pending_o[6]), 32'd0);
`ifdef IRQ_MISSED_CNT_EN
    checkOutput("t5_missed_clr", 32'(missed_cnt_o[55:48]), 32'd0);
`endif
    repeat (3) tick();
    checkOutput("t5_quiet", 32'(irq_o), 32'd0);

    // Reset in the middle of SERVE drops irq_o at once.
    applyStimulus(8'h00, 8'hFF, 8'h00);
    resetDut();
    src_i[2] = 1'b1;
    waitIrq("t6_irq");
    checkOutput("t6_id", 32'(irq_id_o), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_drop", 32'(irq_o), 32'd0);
    src_i = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("t6_no_irq", 32'(irq_o), 32'd0);
    checkOutput("t6_no_pend", 32'(pending_o), 32'd0);
    src_i[2] = 1'b1;
    waitIrq("t6_new_irq");
    checkOutput("t6_new_id", 32'(irq_id_o), 32'd2);
    ackPulse();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/irq_scheduler.md
Name: irq_scheduler

Overview:
- Aggregates NUM_SRC asynchronous interrupt lines into one PS-facing interrupt with a source ID and an ack handshake.
- Per-source path: synchronizer, then registered edge detect, then sticky pending bit.
- Round-robin arbitration among enabled pending sources. A hold-off gap after each ack guarantees a clean deassertion before the next interrupt.
- Sits between PL event sources and the PS IRQ input; configured by the AXI-Lite register block.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..32)
SYNC_STAGES, 2, synchronizer flops per source (>=2)
HOLDOFF, 4, irq_o low cycles after each ack (0..255; 0 = return directly to IDLE)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
src_i  in  NUM_SRC  raw asynchronous interrupt lines
cfg_fall_i  in  NUM_SRC  per-source edge select: 0 = rising, 1 = falling
en_i  in  NUM_SRC  per-source arbitration enable
clr_i  in  NUM_SRC  one-cycle software clear of pending bits
ack_i  in  1  one-cycle host acknowledge of the currently presented ID
irq_o  out  1  interrupt to PS, level
irq_id_o  out  $clog2(NUM_SRC)  ID of the presented source; valid while irq_o=1
pending_o  out  NUM_SRC  sticky pending bits
missed_cnt_o  out  8*NUM_SRC  per-source missed-edge counters (present only with the optional feature)

Behaviour:
- Reset: all sync/delay/edge flops 0; pending_o=0; irq_o=0; irq_id_o=0; state IDLE; last_id=NUM_SRC-1; hold-off counter 0. The synchronizer resets to 0, so a source held high through reset yields a rising edge after release.
- Edge path: edge pulse is registered. A selected edge produces pending=1 exactly SYNC_STAGES+2 clk edges after the first edge that samples the new src_i level. Pulses shorter than one clk period may be lost.
- Pending bits:
  - Set by the edge pulse regardless of en_i.
  - Cleared by clr_i, or by ack_i for the served ID.
  - Set has priority over any clear in the same cycle.
  - An edge arriving while pending is already 1 is lost.
- FSM IDLE:
  - irq_o=0.
  - If (pending & en_i) != 0: grant = first set bit searching last_id+1 upward, wrapping at NUM_SRC-1 to 0.
  - Register irq_id_o=grant and last_id=grant; next state SERVE.
  - irq_o goes high the cycle after pending & en is first seen nonzero.
- FSM SERVE:
  - irq_o=1; irq_id_o held stable.
  - Changes to en_i or clr_i of the served source do not withdraw the interrupt; only ack_i exits SERVE.
  - On ack_i: clear pending[irq_id_o]; next state GAP, or IDLE if HOLDOFF=0; irq_o=0 from the next cycle.
- FSM GAP:
  - irq_o=0; counts HOLDOFF cycles, then IDLE.
  - ack_i outside SERVE is ignored.
- cfg_fall_i change: may cause one spurious edge pulse; software clears it with clr_i.
- Reset asserted mid-SERVE: irq_o drops asynchronously; all state returns to reset values.

Optional Feature:
- Macro IRQ_MISSED_CNT_EN.
- Defined:
  - Per-source 8-bit counter, saturating at 255, increments on each edge pulse that arrives while that source's pending bit is already 1.
  - The counter is cleared by clr_i for that source.
  - Exported on missed_cnt_o, source i at bits [8i+7:8i].
- Undefined: port missed_cnt_o and all counters are absent; lost edges are silent.

Decomposition:
- Package irq_sched_pkg:
  - state enum state_t {IDLE, SERVE, GAP};
  - localparam function for ID width (clog2 with minimum 1);
  - MISSED_CNT_W=8.
- Sub-module irq_edge_sync, instantiated per source via generate: synchronizer chain, delay register, registered rise/fall pulse selected by cfg_fall.
- Arbiter (round-robin search) and FSM stay in the top.

Test Plan:
- Reset then rising edge on src_i[3], en=all ones -> pending_o[3]=1 at cycle SYNC_STAGES+2; irq_o=1 one cycle later with irq_id_o=3; ack_i -> irq_o=0 for 4 cycles, pending_o=0.
- src_i[0], [2], [5] edge in the same cycle -> served in order 0,2,5; after next edges on 0 and 5 with last_id=5 -> order 0,5.
- cfg_fall_i[1]=1, pulse src_i[1] high 10 cycles -> pending set only after the falling edge; en_i[1]=0 -> pending_o[1]=1 but irq_o stays 0 until en_i[1]=1.
- Edge on served source 4 landing in the same cycle as ack_i -> pending_o[4] stays 1; irq re-asserts with ID 4 after the hold-off.
- Three further edges on src 6 while pending (IRQ_MISSED_CNT_EN) -> missed_cnt_o[55:48]=3; 300 further edges -> 255; clr_i[6] -> counter 0, pending 0.
- rst_n low mid-SERVE -> irq_o=0 immediately; after release no irq until a new edge arrives.
